mem_bus_seq: RTL and testbench
==============================

// Module: mem_bus_seq
// PURPOSE
//  Sequences single-word accesses from the MEM-stage access control onto the shared system bus.
//  Requests bus ownership, issues the access strobe and waits for bus ready.
//  Stalls the pipeline through busy and holds read data while the pipeline is stalled.
//  Sits between the MEM-stage access control (req_* side) and the bus arbiter/slaves (bus_* side).
// PARAMETERS
//  TIMEOUT_CYCLES  256  XFER cycles without bus_rdy_ before abort (used only with MEM_BUS_SEQ_TIMEOUT_EN); legal 2..65535
// PORTS
//  clk          in   1   clock, all state on rising edge
//  reset        in   1   asynchronous, active-low reset
//  stall        in   1   pipeline stall; 1 = MEM stage frozen
//  flush        in   1   pipeline flush; 1 = discard pending MEM request
//  req_addr     in   30  word address from MEM stage
//  req_as_      in   1   access strobe, active-low
//  req_rw       in   1   1 = READ, 0 = WRITE
//  req_wr_data  in   32  write data
//  rd_data      out  32  read data returned to MEM stage
//  busy         out  1   1 = access in progress; stall the pipeline
//  bus_req_     out  1   bus request to arbiter, active-low
//  bus_grnt_    in   1   bus grant, active-low
//  bus_addr     out  30  bus word address
//  bus_as_      out  1   bus address strobe, active-low
//  bus_rw       out  1   1 = READ, 0 = WRITE
//  bus_wr_data  out  32  bus write data
//  bus_rd_data  in   32  bus read data; valid when bus_rdy_=0
//  bus_rdy_     in   1   slave ready, active-low
//  bus_err      out  1   one-cycle timeout pulse; constant 0 without the macro
// BEHAVIOUR
//  States: IDLE, ARB, XFER, HOLD.
//  Reset values (registered outputs and state):
//   - state=IDLE, bus_req_=1, bus_as_=1, bus_rw=1
//   - bus_addr=0, bus_wr_data=0, rd_buf=0, bus_err=0
//  IDLE:
//   - req_as_=0 and flush=0: latch addr, rw and wr_data into bus_addr, bus_rw, bus_wr_data; bus_req_<=0; ->ARB.
//   - Otherwise stay in IDLE.
//  ARB:
//   - flush=1 takes priority: bus_req_<=1; ->IDLE; no strobe issued.
//   - Else, when bus_grnt_=0: bus_as_<=0 for exactly one cycle; ->XFER.
//  XFER:
//   - bus_as_<=1 on entry+1; bus_req_ stays 0.
//   - bus_rdy_=0 (may occur in the first XFER cycle): rd_buf<=bus_rd_data on READ, unchanged on WRITE; bus_req_<=1.
//   - Then, if stall=1 and flush=0: ->HOLD; else ->IDLE.
//   - flush does not abort XFER; the transfer completes and read data is discarded (no HOLD).
//  HOLD:
//   - rd_data=rd_buf.
//   - stall=0: ->IDLE; a new request is accepted only from IDLE (next cycle).
//   - flush=1: ->IDLE.
//  busy (combinational):
//   - 1 in IDLE when req_as_=0 and flush=0; 1 in ARB; 1 in XFER until bus_rdy_=0.
//   - 0 in the bus_rdy_=0 cycle and in HOLD.
//  rd_data (combinational):
//   - bus_rd_data in XFER with bus_rdy_=0 and bus_rw=1.
//   - rd_buf in HOLD.
//   - 0 otherwise.
//  Minimum latency: IDLE->ARB->XFER; busy is high 2 cycles when grant and ready are both immediate.
//  Grant withdrawn during XFER is ignored; the transfer continues until bus_rdy_.
//  Reset asserted mid-operation: immediate return to reset values; bus_req_ and bus_as_ deasserted asynchronously.
// CONFIGURATION
//  MEM_BUS_SEQ_TIMEOUT_EN defined:
//   - 16-bit counter cleared on XFER entry, incremented each XFER cycle with bus_rdy_=1.
//   - On reaching TIMEOUT_CYCLES: bus_err=1 for one cycle, bus_req_<=1, rd_buf<=0, ->IDLE.
//   - busy drops in that same cycle.
//  MEM_BUS_SEQ_TIMEOUT_EN undefined: no counter; XFER waits indefinitely; bus_err tied to 0.
// TESTING
//  Read, grant and rdy immediate, addr=0x0000_0010, bus_rd_data=0xDEAD_BEEF:
//   -> bus_as_ low 1 cycle; rd_data=0xDEADBEEF; busy high exactly 2 cycles.
//  Write data 0x1234_5678, grant after 3 cycles, rdy after 2:
//   -> bus_wr_data=0x12345678, bus_rw=0; busy high 6 cycles; bus_req_ released with rdy.
//  Read completes with stall=1 for 4 cycles, bus_rd_data=0xA5A5_A5A5 then 0:
//   -> HOLD; rd_data stays 0xA5A5A5A5 all 4 cycles; IDLE after stall drops.
//  Flush in ARB -> bus_req_=1 next cycle, no bus_as_.
//  Flush in XFER -> transfer completes, no HOLD.
//  Macro on, TIMEOUT_CYCLES=8, bus_rdy_ held 1:
//   -> bus_err pulses once at XFER cycle 8; bus_req_=1; busy=0.
//   -> Reset low mid-XFER: all outputs at reset values immediately.

Source files
------------

// File: rtl/mem_bus_seq.sv
// mem_bus_seq: sequences single-word MEM-stage accesses onto the shared bus; min 2-cycle busy (IDLE->ARB->XFER).
// Backpressure: busy stalls the pipe until bus_rdy_; HOLD keeps read data while stalled. Watchdog: MEM_BUS_SEQ_TIMEOUT_EN.
module mem_bus_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] req_addr,
  input  logic        req_as_,
  input  logic        req_rw,
  input  logic [31:0] req_wr_data,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic [29:0] bus_addr,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, ARB, XFER, HOLD} state_t;

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_as_q, bus_as_d;
  logic        bus_rw_q, bus_rw_d;
  logic [29:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wr_data_q, bus_wr_data_d;
  logic [31:0] rd_buf_q, rd_buf_d;
  logic        bus_err_q, bus_err_d;
  logic        timeout;

`ifdef MEM_BUS_SEQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  // Fires in the last XFER cycle of the window, so busy drops with the abort decision.
  assign timeout = (state_q == XFER) && bus_rdy_ && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ARB && state_d == XFER) begin
      tmo_cnt_d = '0;
    end else if (state_q == XFER && bus_rdy_) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_as_d      = bus_as_q;
    bus_rw_d      = bus_rw_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    rd_buf_d      = rd_buf_q;
    bus_err_d     = 1'b0;
    busy          = 1'b0;
    rd_data       = '0;

    case (state_q)
      IDLE: begin
        if (!req_as_ && !flush) begin
          busy          = 1'b1;
          bus_addr_d    = req_addr;
          bus_rw_d      = req_rw;
          bus_wr_data_d = req_wr_data;
          bus_req_d     = 1'b0;
          state_d       = ARB;
        end
      end
      ARB: begin
        busy = 1'b1;
        if (flush) begin
          bus_req_d = 1'b1;
          state_d   = IDLE;
        end else if (!bus_grnt_) begin
          bus_as_d = 1'b0;
          state_d  = XFER;
        end
      end
      XFER: begin
        // Strobe is a single cycle; grant changes are ignored until the slave answers.
        bus_as_d = 1'b1;
        if (!bus_rdy_) begin
          if (bus_rw_q) begin
            rd_buf_d = bus_rd_data;
            rd_data  = bus_rd_data;
          end
          bus_req_d = 1'b1;
          state_d   = (stall && !flush) ? HOLD : IDLE;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          bus_req_d = 1'b1;
          rd_buf_d  = '0;
          state_d   = IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      HOLD: begin
        rd_data = rd_buf_q;
        if (!stall || flush) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      bus_req_q     <= 1'b1;
      bus_as_q      <= 1'b1;
      bus_rw_q      <= 1'b1;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
      rd_buf_q      <= '0;
      bus_err_q     <= 1'b0;
`ifdef MEM_BUS_SEQ_TIMEOUT_EN
      tmo_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_as_q      <= bus_as_d;
      bus_rw_q      <= bus_rw_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      rd_buf_q      <= rd_buf_d;
      bus_err_q     <= bus_err_d;
`ifdef MEM_BUS_SEQ_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  assign bus_req_    = bus_req_q;
  assign bus_as_     = bus_as_q;
  assign bus_rw      = bus_rw_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_bus_seq.sv
// Directed bench for mem_bus_seq: drives at negedge, samples 1 ns later.
module tb_mem_bus_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush;
  logic [29:0] req_addr;
  logic        req_as_, req_rw;
  logic [31:0] req_wr_data;
  logic [31:0] rd_data;
  logic        busy, bus_req_, bus_grnt_;
  logic [29:0] bus_addr;
  logic        bus_as_, bus_rw;
  logic [31:0] bus_wr_data, bus_rd_data;
  logic        bus_rdy_, bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_bus_seq #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .req_addr(req_addr), .req_as_(req_as_), .req_rw(req_rw), .req_wr_data(req_wr_data),
    .rd_data(rd_data), .busy(busy), .bus_req_(bus_req_), .bus_grnt_(bus_grnt_),
    .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .bus_err(bus_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    req_as_ = 1'b1; flush = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
  endtask

  // One access with an arbiter granting after g_dly ARB cycles and a slave
  // answering after r_dly XFER cycles; returns what was seen in the ready cycle.
  task automatic run_acc(input logic rw, input logic [29:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int g_dly, input int r_dly,
                         input logic stall_done,
                         output int busy_n, output int as_n, output logic [31:0] rd_obs,
                         output logic [29:0] addr_obs, output logic rw_obs,
                         output logic [31:0] wd_obs, output logic done);
    int arb_n, xfer_n;
    logic in_xfer;
    arb_n = 0; xfer_n = 0; in_xfer = 1'b0; done = 1'b0;
    busy_n = 0; as_n = 0; rd_obs = '0; addr_obs = '0; rw_obs = 1'b0; wd_obs = '0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      req_as_ = 1'b0; req_addr = addr; req_rw = rw; req_wr_data = wd;
      stall = stall_done; flush = 1'b0;
      if (!bus_as_) in_xfer = 1'b1;
      bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = ~rd;
      if (in_xfer) begin
        if (xfer_n >= r_dly) begin
          bus_rdy_ = 1'b0; bus_rd_data = rd;
        end
        xfer_n++;
      end else if (!bus_req_) begin
        bus_grnt_ = (arb_n < g_dly);
        arb_n++;
      end
      #1;
      if (busy) busy_n++;
      if (!bus_as_) as_n++;
      if (in_xfer && !bus_rdy_) begin
        rd_obs = rd_data; addr_obs = bus_addr; rw_obs = bus_rw; wd_obs = bus_wr_data;
        done = 1'b1;
      end
    end
  endtask

  int          busy_n, as_n;
  logic [31:0] rd_obs, wd_obs;
  logic [29:0] addr_obs;
  logic        rw_obs, done;

  initial begin
    reset = 1'b0; stall = 1'b0; req_addr = '0; req_rw = 1'b0; req_wr_data = '0;
    idle_inputs();
    #12;
    check_eq("rst_bus_req_", bus_req_, 1);
    check_eq("rst_bus_as_", bus_as_, 1);
    check_eq("rst_bus_rw", bus_rw, 1);
    check_eq("rst_bus_addr", bus_addr, 0);
    check_eq("rst_bus_wr_data", bus_wr_data, 0);
    check_eq("rst_bus_err", bus_err, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rd_data", rd_data, 0);
    @(negedge clk); reset = 1'b1;

    // Read, immediate grant and ready
    run_acc(1'b1, 30'h10, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0,
            busy_n, as_n, rd_obs, addr_obs, rw_obs, wd_obs, done);
    check_eq("rd_done", done, 1);
    check_eq("rd_busy_cycles", busy_n, 2);
    check_eq("rd_as_cycles", as_n, 1);
    check_eq("rd_data", rd_obs, 32'hDEAD_BEEF);
    check_eq("rd_addr", addr_obs, 32'h10);
    check_eq("rd_rw", rw_obs, 1);
    @(negedge clk); idle_inputs(); stall = 1'b0; #1;
    check_eq("rd_req_released", bus_req_, 1);
    check_eq("rd_idle_busy", busy, 0);
    check_eq("rd_idle_rd_data", rd_data, 0);

    // Write, grant after 3 ARB cycles, ready in 2nd XFER cycle, stalled at completion
    run_acc(1'b0, 30'h2A, 32'h1234_5678, 32'hFFFF_0000, 3, 1, 1'b1,
            busy_n, as_n, rd_obs, addr_obs, rw_obs, wd_obs, done);
    check_eq("wr_done", done, 1);
    check_eq("wr_busy_cycles", busy_n, 6);
    check_eq("wr_as_cycles", as_n, 1);
    check_eq("wr_wr_data", wd_obs, 32'h1234_5678);
    check_eq("wr_rw", rw_obs, 0);
    @(negedge clk); idle_inputs(); stall = 1'b1; #1;
    check_eq("wr_req_released", bus_req_, 1);
    check_eq("wr_hold_busy", busy, 0);
    check_eq("wr_hold_keeps_buf", rd_data, 32'hDEAD_BEEF);
    @(negedge clk); stall = 1'b0; #1;
    check_eq("wr_hold_last", rd_data, 32'hDEAD_BEEF);
    @(negedge clk); #1;
    check_eq("wr_idle_rd_data", rd_data, 0);

    // Read completing under a 4-cycle stall
    run_acc(1'b1, 30'h100, 32'h0, 32'hA5A5_A5A5, 0, 0, 1'b1,
            busy_n, as_n, rd_obs, addr_obs, rw_obs, wd_obs, done);
    check_eq("st_done", done, 1);
    check_eq("st_rd_c1", rd_obs, 32'hA5A5_A5A5);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk); idle_inputs(); stall = 1'b1; #1;
      check_eq($sformatf("st_rd_c%0d", i), rd_data, 32'hA5A5_A5A5);
      check_eq($sformatf("st_busy_c%0d", i), busy, 0);
    end
    @(negedge clk); stall = 1'b0; #1;
    check_eq("st_hold_exit", rd_data, 32'hA5A5_A5A5);
    @(negedge clk); #1;
    check_eq("st_idle_rd_data", rd_data, 0);
    check_eq("st_idle_busy", busy, 0);

    // Flush in ARB: grant present, but no strobe and request dropped
    @(negedge clk); req_as_ = 1'b0; req_rw = 1'b1; req_addr = 30'h3; #1;
    check_eq("fa_idle_busy", busy, 1);
    @(negedge clk); req_as_ = 1'b1; flush = 1'b1; bus_grnt_ = 1'b0; #1;
    check_eq("fa_arb_busy", busy, 1);
    check_eq("fa_arb_req", bus_req_, 0);
    @(negedge clk); flush = 1'b0; #1;
    check_eq("fa_req_dropped", bus_req_, 1);
    check_eq("fa_no_as_1", bus_as_, 1);
    check_eq("fa_busy", busy, 0);
    @(negedge clk); #1;
    check_eq("fa_no_as_2", bus_as_, 1);
    @(negedge clk); idle_inputs();

    // Flush in XFER: transfer still completes, no HOLD even with stall
    @(negedge clk); req_as_ = 1'b0; req_rw = 1'b1; req_addr = 30'h7; #1;
    @(negedge clk); bus_grnt_ = 1'b0; #1;
    @(negedge clk); bus_grnt_ = 1'b1; req_as_ = 1'b1; flush = 1'b1; stall = 1'b1; #1;
    check_eq("fx_as_low", bus_as_, 0);
    check_eq("fx_busy_kept", busy, 1);
    @(negedge clk); bus_rdy_ = 1'b0; bus_rd_data = 32'h0BAD_F00D; #1;
    check_eq("fx_req_kept", bus_req_, 0);
    check_eq("fx_rdy_busy", busy, 0);
    @(negedge clk); bus_rdy_ = 1'b1; bus_rd_data = '0; flush = 1'b0; #1;
    check_eq("fx_no_hold", rd_data, 0);
    check_eq("fx_req_dropped", bus_req_, 1);
    @(negedge clk); idle_inputs(); stall = 1'b0;

    // Asynchronous reset in the strobe cycle of a write
    @(negedge clk); req_as_ = 1'b0; req_rw = 1'b0; req_addr = 30'h155; req_wr_data = 32'hCAFE_F00D; #1;
    @(negedge clk); bus_grnt_ = 1'b0; #1;
    @(negedge clk); bus_grnt_ = 1'b1; req_as_ = 1'b1; #1;
    check_eq("ar_pre_as", bus_as_, 0);
    check_eq("ar_pre_rw", bus_rw, 0);
    #1 reset = 1'b0; #1;
    check_eq("ar_bus_req_", bus_req_, 1);
    check_eq("ar_bus_as_", bus_as_, 1);
    check_eq("ar_bus_rw", bus_rw, 1);
    check_eq("ar_bus_addr", bus_addr, 0);
    check_eq("ar_bus_wr_data", bus_wr_data, 0);
    check_eq("ar_busy", busy, 0);
    @(negedge clk); reset = 1'b1;

`ifdef MEM_BUS_SEQ_TIMEOUT_EN
    // Watchdog with TIMEOUT_CYCLES=8 and a slave that never answers
    begin
      int xbusy, xerr;
      xbusy = 0; xerr = 0;
      @(negedge clk); req_as_ = 1'b0; req_rw = 1'b1; req_addr = 30'h9; #1;
      @(negedge clk); bus_grnt_ = 1'b0; #1;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk); bus_grnt_ = 1'b1; req_as_ = 1'b1; #1;
        if (busy) xbusy++;
        if (bus_err) xerr++;
      end
      check_eq("to_busy_cycles", xbusy, 7);
      check_eq("to_no_early_err", xerr, 0);
      @(negedge clk); #1;
      check_eq("to_err_pulse", bus_err, 1);
      check_eq("to_req_dropped", bus_req_, 1);
      check_eq("to_busy", busy, 0);
      @(negedge clk); #1;
      check_eq("to_err_single", bus_err, 0);
    end
`else
    check_eq("no_tmo_bus_err", bus_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
